// File: rtl/divclk_monitor_if.sv
// Bundle between the clock divider and its receive-side monitor.
// The master drives the divided clock and valid flag; the slave reports status.
interface divclk_monitor_if #(
    parameter int CW = 8,
    parameter int EW = 8
);
    logic          div_clk;
    logic          div_valid;
    logic          locked;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] half_period;
    logic          err_pulse;
    logic [EW-1:0] err_count;

    modport master (
        output div_clk,
        output div_valid,
        input  locked,
        input  rise_pulse,
        input  fall_pulse,
        input  half_period,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  div_clk,
        input  div_valid,
        output locked,
        output rise_pulse,
        output fall_pulse,
        output half_period,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/divclk_monitor.sv
// Receive-side checker for a divided clock sampled as data in the clk domain.
// Measures half-periods, locks after LOCK_CNT good ones, flags ratio errors and stalls.
module divclk_monitor #(
    parameter int DIV_HALF = 2,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8,
    parameter int EW       = 8
) (
    input logic         clk,
    input logic         rst,
    divclk_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        TRACK,
        LOCKED
    } state_t;

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] HALF  = CW'(DIV_HALF);
    localparam logic [CW-1:0] STALL = CW'(2 * DIV_HALF);
    localparam logic [GW-1:0] GLAST = GW'(LOCK_CNT - 1);

    state_t        state;
    logic          prev;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] hinc;
    logic [GW-1:0] good_cnt;
    logic          edg;
    logic          active;
    logic          pulse_ok;
    logic          good_edge;
    logic          bad_edge;
    logic          stall;
    logic          err_now;

    always_comb begin
        edg       = bus.div_clk != prev;
        hinc      = (hcnt == '1) ? hcnt : hcnt + CW'(1);
        active    = bus.div_valid &&
                    (state == TRACK || state == LOCKED);
        pulse_ok  = bus.div_valid && state != IDLE && edg;
        good_edge = active && edg && hcnt == HALF;
        bad_edge  = active && edg && hcnt != HALF;
        stall     = active && !edg && hcnt == STALL;
        err_now   = bad_edge || stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            prev            <= 1'b0;
            hcnt            <= '0;
            good_cnt        <= '0;
            bus.locked      <= 1'b0;
            bus.rise_pulse  <= 1'b0;
            bus.fall_pulse  <= 1'b0;
            bus.half_period <= '0;
            bus.err_pulse   <= 1'b0;
            bus.err_count   <= '0;
        end else begin
            prev           <= bus.div_clk;
            hcnt           <= edg ? CW'(1) : hinc;
            bus.rise_pulse <= pulse_ok && bus.div_clk;
            bus.fall_pulse <= pulse_ok && !bus.div_clk;
            bus.err_pulse  <= err_now;
            if (err_now && bus.err_count != '1)
                bus.err_count <= bus.err_count + EW'(1);
            if (active && edg)
                bus.half_period <= hcnt;

            // Losing valid overrides whatever the current state would do.
            if (!bus.div_valid) begin
                state      <= IDLE;
                bus.locked <= 1'b0;
                good_cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: state <= HUNT;
                    HUNT: begin
                        if (edg) begin
                            good_cnt <= '0;
                            state    <= TRACK;
                        end
                    end
                    TRACK, LOCKED: begin
                        if (good_edge && state == TRACK) begin
                            good_cnt <= good_cnt + GW'(1);
                            if (good_cnt == GLAST) begin
                                state      <= LOCKED;
                                bus.locked <= 1'b1;
                            end
                        end else if (bad_edge) begin
                            good_cnt   <= '0;
                            bus.locked <= 1'b0;
                            state      <= TRACK;
                        end else if (stall) begin
                            good_cnt   <= '0;
                            bus.locked <= 1'b0;
                            state      <= HUNT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_divclk_monitor.sv
// Directed bench for divclk_monitor with default parameters.
// Expected values are hand-derived from the monitor's timing.
module tb_divclk_monitor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_rise;
    int   n_fall;
    int   n_err;
    logic p_rise;
    logic p_fall;
    logic p_err;
    logic p2_err;
    logic p2_pulse;
    int   e0;

    divclk_monitor_if #(.CW(8), .EW(8)) bus ();

    divclk_monitor #(
        .DIV_HALF(2),
        .LOCK_CNT(4),
        .CW(8),
        .EW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic dc);
        bus.div_clk = dc;
        @(posedge clk);
        #1;
        if (bus.rise_pulse) n_rise++;
        if (bus.fall_pulse) n_fall++;
        if (bus.err_pulse)  n_err++;
    endtask

    task automatic half(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            tick(lvl);
            if (i == 0) begin
                p_rise = bus.rise_pulse;
                p_fall = bus.fall_pulse;
                p_err  = bus.err_pulse;
            end
            if (i == 1) begin
                p2_err   = bus.err_pulse;
                p2_pulse = bus.rise_pulse | bus.fall_pulse;
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        n_rise = 0; n_fall = 0; n_err = 0;
        rst = 1'b1;
        bus.div_valid = 1'b1;
        bus.div_clk = 1'b0;

        // 1: reset wins over a toggling div_clk
        for (int i = 0; i < 3; i++) begin
            tick(i[0] ? 1'b0 : 1'b1);
            chk("rst_locked", 32'(bus.locked), 0);
            chk("rst_pulses",
                32'(bus.rise_pulse | bus.fall_pulse | bus.err_pulse), 0);
            chk("rst_errcnt", 32'(bus.err_count), 0);
        end
        chk("rst_hp", 32'(bus.half_period), 0);

        // 2: align edge then four good edges
        rst = 1'b0;
        tick(1'b0);
        n_rise = 0; n_fall = 0; n_err = 0;
        half(1'b1, 2);
        chk("align_rise", 32'(p_rise), 1);
        chk("align_hp", 32'(bus.half_period), 0);
        half(1'b0, 2);
        chk("g1_fall", 32'(p_fall), 1);
        chk("g1_norise", 32'(p_rise), 0);
        chk("g1_pulse_len", 32'(p2_pulse), 0);
        half(1'b1, 2);
        half(1'b0, 2);
        chk("g3_unlocked", 32'(bus.locked), 0);
        half(1'b1, 2);
        chk("g4_locked", 32'(bus.locked), 1);
        chk("g4_hp", 32'(bus.half_period), 2);
        chk("g4_errcnt", 32'(bus.err_count), 0);
        chk("g4_nrise", 32'(n_rise), 3);
        chk("g4_nfall", 32'(n_fall), 2);

        // 3: one half-period of 3 while locked
        half(1'b0, 3);
        chk("long_goodedge", 32'(p_err), 0);
        chk("long_stilllock", 32'(bus.locked), 1);
        half(1'b1, 2);
        chk("bad_err", 32'(p_err), 1);
        chk("bad_err_len", 32'(p2_err), 0);
        chk("bad_errcnt", 32'(bus.err_count), 1);
        chk("bad_unlock", 32'(bus.locked), 0);
        chk("bad_hp", 32'(bus.half_period), 3);
        half(1'b0, 2);
        half(1'b1, 2);
        half(1'b0, 2);
        chk("re3_unlocked", 32'(bus.locked), 0);
        half(1'b1, 2);
        chk("re4_locked", 32'(bus.locked), 1);
        chk("re4_hp", 32'(bus.half_period), 2);

        // 4: div_clk held high -> stall at hcnt=4
        tick(1'b1);
        chk("st_a_err", 32'(bus.err_pulse), 0);
        tick(1'b1);
        chk("st_b_err", 32'(bus.err_pulse), 0);
        chk("st_b_lock", 32'(bus.locked), 1);
        tick(1'b1);
        chk("st_err", 32'(bus.err_pulse), 1);
        chk("st_unlock", 32'(bus.locked), 0);
        chk("st_errcnt", 32'(bus.err_count), 2);
        tick(1'b1);
        chk("st_once", 32'(bus.err_pulse), 0);
        half(1'b0, 2);
        chk("st_align_noerr", 32'(p_err), 0);
        chk("st_align_fall", 32'(p_fall), 1);
        chk("st_align_hp", 32'(bus.half_period), 2);
        half(1'b1, 2);
        half(1'b0, 2);
        half(1'b1, 2);
        chk("st_re3", 32'(bus.locked), 0);
        half(1'b0, 2);
        chk("st_re4", 32'(bus.locked), 1);
        chk("st_re_errcnt", 32'(bus.err_count), 2);

        // 5: valid drops on the same posedge as an edge
        bus.div_valid = 1'b0;
        tick(1'b1);
        chk("inv_unlock", 32'(bus.locked), 0);
        chk("inv_norise", 32'(bus.rise_pulse), 0);
        chk("inv_errcnt", 32'(bus.err_count), 2);
        tick(1'b0);
        chk("idle_nofall", 32'(bus.fall_pulse), 0);
        chk("idle_noerr", 32'(bus.err_pulse), 0);

        // 6: 300 bad half-periods saturate the counter
        bus.div_valid = 1'b1;
        tick(1'b0);
        half(1'b1, 3);
        chk("sat_align_noerr", 32'(p_err), 0);
        e0 = n_err;
        for (int i = 0; i < 300; i++)
            half(i[0] ? 1'b1 : 1'b0, 3);
        chk("sat_errcnt", 32'(bus.err_count), 255);
        chk("sat_npulses", 32'(n_err - e0), 300);
        chk("sat_unlocked", 32'(bus.locked), 0);
        chk("sat_hp", 32'(bus.half_period), 3);
        rst = 1'b1;
        tick(1'b0);
        chk("sat_rst_cnt", 32'(bus.err_count), 0);
        chk("sat_rst_hp", 32'(bus.half_period), 0);
        chk("sat_rst_lock", 32'(bus.locked), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
